logic_op_sequencer: RTL and testbench
=====================================

Name: logic_op_sequencer

Overview:
Command-driven sequencer that operates the combinational LogicalUnit (8-bit a, b, 3-bit sel, 8-bit out) as a clocked peer. It accepts logical-operation commands over a valid/ready handshake and reads operands from a 4x8 internal register file. It drives the LogicalUnit inputs, captures its output, writes the result back, and returns result plus flags over a second valid/ready handshake. It sits between the future instruction decoder and the ALU logical datapath.

Parameters:
NREGS, 4, number of 8-bit operand registers; address width is clog2(NREGS), which is 2 at the default.
W, 8, datapath width; must match the LogicalUnit width.

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
reg_wr_en  input  1  preload strobe for the register file
reg_wr_addr  input  2  preload address
reg_wr_data  input  8  preload data
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  LogicalUnit select code
cmd_src_a  input  2  register index for operand a
cmd_src_b  input  2  register index for operand b
cmd_dst  input  2  write-back register index
lu_a  output  8  to LogicalUnit a
lu_b  output  8  to LogicalUnit b
lu_sel  output  3  to LogicalUnit sel
lu_out  input  8  from LogicalUnit out (combinational)
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_data  output  8  captured result
rsp_zero  output  1  high when rsp_data == 0
rsp_parity  output  1  XOR-reduce of rsp_data (odd parity)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All registers in the register file cleared to 0x00.
  - lu_a, lu_b, lu_sel, rsp_data, rsp_zero, rsp_parity all 0; rsp_valid=0; cmd_ready=1 after reset is released.
- FSM states: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
- IDLE:
  - cmd_ready=1.
  - A handshake (cmd_valid & cmd_ready) latches op, src_a, src_b and dst, then moves to ISSUE.
- ISSUE (one cycle):
  - Registers lu_a <= rf[src_a], lu_b <= rf[src_b], lu_sel <= op.
  - cmd_ready=0.
- CAPTURE (one cycle):
  - Samples lu_out into rsp_data and computes the flags from lu_out.
  - Writes rf[dst] <= lu_out.
  - Moves to RESP.
- RESP:
  - rsp_valid=1; rsp_data and the flags are held stable until rsp_ready=1.
  - On the handshake, moves to IDLE and drops rsp_valid the next cycle.
- Latency: command accept at edge N; rsp_valid is high from N+3. Minimum throughput is one command per 4 cycles when rsp_ready is held high.
- lu_a, lu_b and lu_sel are updated only in ISSUE and hold their values otherwise. This keeps the LogicalUnit output stable through CAPTURE and RESP.
- Preload:
  - reg_wr_en is honored only in IDLE and is silently ignored in all other states.
  - If a preload and a command accept occur in the same IDLE cycle, the write commits at that edge. ISSUE therefore reads the new value.
- Hazards:
  - Write-back in CAPTURE is complete before the next IDLE. Back-to-back commands that read the previous dst see the updated value.
  - src_a == src_b == dst is legal.
- cmd_valid may drop without acceptance; there are no sticky requirements on the producer.
- Reset asserted mid-operation aborts immediately. Any in-flight result is discarded, with no partial write-back beyond edges already taken.
- All widths are exactly 8 bits; there is no carry, overflow or sign handling in this block.

Decomposition:
- Shared package alu_pkg:
  - 3-bit op constants OP_AND=0, OP_OR=1, OP_XOR=2, OP_NAND=3, OP_NOR=4, OP_XNOR=5, OP_NOTA=6, OP_PASSB=7.
  - FSM state encoding: IDLE=0, ISSUE=1, CAPTURE=2, RESP=3.
- Sub-module operand_regfile: NREGS x W, two combinational read ports and one write port. It is shared by the preload and write-back paths through a mux in the sequencer.
- The LogicalUnit is instantiated outside this block. The bench instantiates both and connects the lu_* ports.

Test Plan:
1. Reset: hold rst_n=0, then release -> cmd_ready=1, rsp_valid=0, lu_a=lu_b=0x00, lu_sel=0.
2. Preload rf0=0x35, rf1=0xAA; cmd op=AND, src_a=0, src_b=1, dst=2 -> rsp_valid at accept+3, rsp_data=0x20, zero=0, parity=1; a following op=PASSB with src_b=2 returns 0x20.
3. Same operands, op=OR -> 0xBF, parity=1; op=XOR -> 0x9F, parity=0; op=NAND -> 0xDF.
4. rsp_ready held low for 5 cycles -> rsp_valid and rsp_data stay stable, cmd_ready=0, and a reg_wr_en pulse during the stall does not change rf.
5. rf0=0xFF, rf1=0x00, op=AND, dst=0 -> rsp_data=0x00, zero=1; the next command reads rf0=0x00.
6. Drop rst_n during CAPTURE -> outputs are 0 asynchronously, rf is cleared, and the FSM returns to IDLE with no response issued.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU logical datapath:
//   lu_op_e     - 3-bit LogicalUnit select codes
//   seq_state_e - logic_op_sequencer FSM state encoding
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND   = 3'd0,
      OP_OR    = 3'd1,
      OP_XOR   = 3'd2,
      OP_NAND  = 3'd3,
      OP_NOR   = 3'd4,
      OP_XNOR  = 3'd5,
      OP_NOTA  = 3'd6,
      OP_PASSB = 3'd7
   } lu_op_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } seq_state_e;

endpackage

// File: rtl/operand_regfile.sv
// -----------------------------------------------------------------------------
// operand_regfile
// NREGS x W operand register file, two combinational read ports, one write port.
// Ports:
//   clk, rst_n         - clock, async active-low reset (clears every entry)
//   we, waddr, wdata   - write port, committed on the rising edge
//   raddr_a / rdata_a  - read port A (combinational)
//   raddr_b / rdata_b  - read port B (combinational)
// -----------------------------------------------------------------------------
module operand_regfile #(
   parameter  int NREGS = 4,
   parameter  int W     = 8,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr_a,
   output logic [W-1:0]  rdata_a,
   input  logic [AW-1:0] raddr_b,
   output logic [W-1:0]  rdata_b
);

   logic [W-1:0] mem [NREGS];

   // NOTE: this array is built from flops, not a RAM macro, so it can and must
   // be cleared by the async reset; a real RAM would have no reset port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/logic_op_sequencer.sv
// -----------------------------------------------------------------------------
// logic_op_sequencer
// Drives an external combinational LogicalUnit as a clocked peer. A command
// (op, src_a, src_b, dst) is accepted in IDLE. Operands are issued from the
// register file in ISSUE. The LogicalUnit output is captured and written back
// in CAPTURE. The result and its flags are offered in RESP until consumed.
// Ports:
//   clk, rst_n                         - clock, async active-low reset
//   reg_wr_en/addr/data                - register preload (honoured in IDLE only)
//   cmd_valid/ready, cmd_op/src_a/src_b/dst - command handshake
//   lu_a, lu_b, lu_sel / lu_out        - to / from the LogicalUnit
//   rsp_valid/ready, rsp_data/zero/parity - response handshake
// -----------------------------------------------------------------------------
module logic_op_sequencer
   import alu_pkg::*;
#(
   parameter  int NREGS = 4,
   parameter  int W     = 8,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            reg_wr_en,
   input  logic [AW-1:0]   reg_wr_addr,
   input  logic [W-1:0]    reg_wr_data,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [OP_W-1:0] cmd_op,
   input  logic [AW-1:0]   cmd_src_a,
   input  logic [AW-1:0]   cmd_src_b,
   input  logic [AW-1:0]   cmd_dst,
   output logic [W-1:0]    lu_a,
   output logic [W-1:0]    lu_b,
   output logic [OP_W-1:0] lu_sel,
   input  logic [W-1:0]    lu_out,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [W-1:0]    rsp_data,
   output logic            rsp_zero,
   output logic            rsp_parity
);

   seq_state_e    state, state_nxt;
   lu_op_e        op_q;
   logic [AW-1:0] src_a_q, src_b_q, dst_q;

   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [W-1:0]  rf_wdata, rf_rdata_a, rf_rdata_b;

   // ---------------------------------------------------------------------------
   // Next state, handshake outputs and the register-file write mux.
   // NOTE: every signal driven here gets a default before the case statement,
   // so no path leaves one unassigned and no latch is inferred.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      rf_we     = 1'b0;
      rf_waddr  = reg_wr_addr;
      rf_wdata  = reg_wr_data;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            rf_we     = reg_wr_en;   // preload is legal only while idle
            if (cmd_valid) state_nxt = ISSUE;
         end
         ISSUE: begin
            state_nxt = CAPTURE;
         end
         CAPTURE: begin
            // write-back lands before the next IDLE, so a following command
            // reading dst sees the fresh value
            rf_we     = 1'b1;
            rf_waddr  = dst_q;
            rf_wdata  = lu_out;
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: all clocked state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Command fields are latched on the accept edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= OP_AND;
         src_a_q <= '0;
         src_b_q <= '0;
         dst_q   <= '0;
      end else if (state == IDLE && cmd_valid) begin
         op_q    <= lu_op_e'(cmd_op);
         src_a_q <= cmd_src_a;
         src_b_q <= cmd_src_b;
         dst_q   <= cmd_dst;
      end
   end

   // LogicalUnit inputs change only in ISSUE, keeping lu_out steady afterwards
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lu_a   <= '0;
         lu_b   <= '0;
         lu_sel <= '0;
      end else if (state == ISSUE) begin
         lu_a   <= rf_rdata_a;
         lu_b   <= rf_rdata_b;
         lu_sel <= op_q;
      end
   end

   // Result and flags are captured once and held through RESP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data   <= '0;
         rsp_zero   <= 1'b0;
         rsp_parity <= 1'b0;
      end else if (state == CAPTURE) begin
         rsp_data   <= lu_out;
         rsp_zero   <= (lu_out == '0);
         rsp_parity <= ^lu_out;
      end
   end

   operand_regfile #(
      .NREGS (NREGS),
      .W     (W)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (rf_we),
      .waddr   (rf_waddr),
      .wdata   (rf_wdata),
      .raddr_a (src_a_q),
      .rdata_a (rf_rdata_a),
      .raddr_b (src_b_q),
      .rdata_b (rf_rdata_b)
   );

endmodule

// File: tb/tb_logic_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_logic_op_sequencer
// Bench for logic_op_sequencer. A behavioural LogicalUnit is modelled with a
// continuous assignment. The expected results come from a 4-entry array that
// mirrors the architectural register file, updated by command semantics only.
// -----------------------------------------------------------------------------
module tb_logic_op_sequencer;
   import alu_pkg::*;

   localparam time CLK_PERIOD = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       reg_wr_en;
   logic [1:0] reg_wr_addr;
   logic [7:0] reg_wr_data;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [1:0] cmd_src_a, cmd_src_b, cmd_dst;
   logic [7:0] lu_a, lu_b, lu_out;
   logic [2:0] lu_sel;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_zero, rsp_parity;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] rf_m [4];     // architectural register contents
   time        accept_t;

   always #(CLK_PERIOD/2) clk = ~clk;

   function automatic logic [7:0] lu_eval(input logic [2:0] sel,
                                          input logic [7:0] a, input logic [7:0] b);
      case (sel)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return ~(a ^ b);
         3'd6:    return ~a;
         default: return b;
      endcase
   endfunction

   assign lu_out = lu_eval(lu_sel, lu_a, lu_b);

   logic_op_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .reg_wr_en   (reg_wr_en),
      .reg_wr_addr (reg_wr_addr),
      .reg_wr_data (reg_wr_data),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_src_a   (cmd_src_a),
      .cmd_src_b   (cmd_src_b),
      .cmd_dst     (cmd_dst),
      .lu_a        (lu_a),
      .lu_b        (lu_b),
      .lu_sel      (lu_sel),
      .lu_out      (lu_out),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_zero    (rsp_zero),
      .rsp_parity  (rsp_parity)
   );

   // Preload one register; starts and ends right after a falling edge.
   task automatic preload(input logic [1:0] addr, input logic [7:0] data);
      reg_wr_en   = 1'b1;
      reg_wr_addr = addr;
      reg_wr_data = data;
      rf_m[addr]  = data;
      @(negedge clk);
      reg_wr_en   = 1'b0;
   endtask

   // One full command. Entered right after a falling edge with the DUT idle;
   // returns right after the falling edge following the response handshake.
   task automatic run_cmd(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                          input logic [1:0] dst, input int stall, input bit pre_en,
                          input logic [1:0] pre_addr, input logic [7:0] pre_data,
                          output logic [7:0] got);
      logic [7:0] exp, exp_a, exp_b;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_err++; $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready);
      end
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_src_a   = sa;
      cmd_src_b   = sb;
      cmd_dst     = dst;
      reg_wr_en   = pre_en;
      reg_wr_addr = pre_addr;
      reg_wr_data = pre_data;
      rsp_ready   = (stall == 0);
      if (pre_en) rf_m[pre_addr] = pre_data;   // same-cycle preload is visible
      exp_a = rf_m[sa];
      exp_b = rf_m[sb];
      exp   = lu_eval(op, exp_a, exp_b);
      @(posedge clk);
      accept_t = $time;
      @(negedge clk);                          // first cycle after accept
      cmd_valid = 1'b0;
      reg_wr_en = 1'b0;
      n_cmp++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
         n_err++; $display("FAIL issue_hs: got valid=%b ready=%b want 0/0", rsp_valid, cmd_ready);
      end
      @(negedge clk);                          // second cycle: operands driven
      n_cmp++;
      if (lu_a !== exp_a || lu_b !== exp_b || lu_sel !== op || rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL lu_drive: got a=%h b=%h sel=%0d valid=%b want a=%h b=%h sel=%0d valid=0",
                  lu_a, lu_b, lu_sel, rsp_valid, exp_a, exp_b, op);
      end
      rf_m[dst] = exp;
      @(negedge clk);                          // third cycle: response offered
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_zero !== (exp == 8'h00) ||
          rsp_parity !== (^exp)) begin
         n_err++;
         $display("FAIL response: got v=%b d=%h z=%b p=%b want v=1 d=%h z=%b p=%b",
                  rsp_valid, rsp_data, rsp_zero, rsp_parity, exp, (exp == 8'h00), ^exp);
      end
      got = rsp_data;
      for (int i = 0; i < stall; i++) begin
         // junk traffic while stalled: must be ignored entirely
         reg_wr_en   = (i == 0);
         reg_wr_addr = 2'($urandom_range(0, 3));
         reg_wr_data = 8'($urandom);
         cmd_valid   = 1'b1;
         cmd_op      = 3'($urandom);
         @(negedge clk);
         reg_wr_en = 1'b0;
         cmd_valid = 1'b0;
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_data !== exp || cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold: got v=%b d=%h ready=%b want v=1 d=%h ready=0",
                     rsp_valid, rsp_data, cmd_ready, exp);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         n_err++; $display("FAIL rsp_done: got valid=%b ready=%b want 0/1", rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; reg_wr_en = 1'b0; reg_wr_addr = '0; reg_wr_data = '0;
      cmd_valid = 1'b0; cmd_op = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) rf_m[i] = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_hs: got ready=%b valid=%b want 1/0", cmd_ready, rsp_valid);
      end
      n_cmp++;
      if (lu_a !== 8'h00 || lu_b !== 8'h00 || lu_sel !== 3'd0) begin
         n_err++; $display("FAIL reset_lu: got a=%h b=%h sel=%0d want 0/0/0", lu_a, lu_b, lu_sel);
      end
      n_cmp++;
      if (rsp_data !== 8'h00 || rsp_zero !== 1'b0 || rsp_parity !== 1'b0) begin
         n_err++; $display("FAIL reset_rsp: got d=%h z=%b p=%b want 0/0/0", rsp_data, rsp_zero, rsp_parity);
      end
   endtask

   task automatic test_basic_ops();
      logic [7:0] got;
      preload(2'd0, 8'h35);
      preload(2'd1, 8'hAA);
      run_cmd(OP_AND, 2'd0, 2'd1, 2'd2, 0, 1'b0, 2'd0, 8'h00, got);
      n_cmp++;
      if (got !== 8'h20) begin n_err++; $display("FAIL and_const: got %h want 20", got); end
      run_cmd(OP_PASSB, 2'd0, 2'd2, 2'd3, 0, 1'b0, 2'd0, 8'h00, got);
      n_cmp++;
      if (got !== 8'h20) begin n_err++; $display("FAIL passb_wb: got %h want 20", got); end
      run_cmd(OP_OR, 2'd0, 2'd1, 2'd3, 0, 1'b0, 2'd0, 8'h00, got);
      n_cmp++;
      if (got !== 8'hBF) begin n_err++; $display("FAIL or_const: got %h want bf", got); end
      run_cmd(OP_XOR, 2'd0, 2'd1, 2'd3, 0, 1'b0, 2'd0, 8'h00, got);
      n_cmp++;
      if (got !== 8'h9F) begin n_err++; $display("FAIL xor_const: got %h want 9f", got); end
      run_cmd(OP_NAND, 2'd0, 2'd1, 2'd3, 0, 1'b0, 2'd0, 8'h00, got);
      n_cmp++;
      if (got !== 8'hDF) begin n_err++; $display("FAIL nand_const: got %h want df", got); end
      run_cmd(OP_NOR,  2'd0, 2'd1, 2'd3, 0, 1'b0, 2'd0, 8'h00, got);
      run_cmd(OP_XNOR, 2'd0, 2'd1, 2'd3, 0, 1'b0, 2'd0, 8'h00, got);
      run_cmd(OP_NOTA, 2'd0, 2'd1, 2'd3, 0, 1'b0, 2'd0, 8'h00, got);
   endtask

   task automatic test_stall();
      logic [7:0] got;
      run_cmd(OP_AND, 2'd0, 2'd1, 2'd2, 5, 1'b0, 2'd0, 8'h00, got);
      // every register must still hold its pre-stall value
      for (int r = 0; r < 4; r++) begin
         run_cmd(OP_PASSB, 2'd0, 2'(r), 2'(r), 0, 1'b0, 2'd0, 8'h00, got);
      end
   endtask

   task automatic test_zero_hazard();
      logic [7:0] got;
      preload(2'd0, 8'hFF);
      preload(2'd1, 8'h00);
      run_cmd(OP_AND, 2'd0, 2'd1, 2'd0, 0, 1'b0, 2'd0, 8'h00, got);
      n_cmp++;
      if (got !== 8'h00 || rsp_zero !== 1'b1) begin
         n_err++; $display("FAIL zero_flag: got d=%h z=%b want 00/1", got, rsp_zero);
      end
      run_cmd(OP_NOTA, 2'd0, 2'd1, 2'd3, 0, 1'b0, 2'd0, 8'h00, got);
      n_cmp++;
      if (got !== 8'hFF) begin n_err++; $display("FAIL hazard_rd: got %h want ff", got); end
      // all three indices equal
      preload(2'd2, 8'h6C);
      run_cmd(OP_XNOR, 2'd2, 2'd2, 2'd2, 0, 1'b0, 2'd0, 8'h00, got);
      run_cmd(OP_PASSB, 2'd0, 2'd2, 2'd1, 0, 1'b0, 2'd0, 8'h00, got);
   endtask

   task automatic test_preload_same_cycle();
      logic [7:0] got;
      run_cmd(OP_OR, 2'd3, 2'd1, 2'd0, 0, 1'b1, 2'd3, 8'h3C, got);
      run_cmd(OP_XOR, 2'd0, 2'd2, 2'd2, 1, 1'b1, 2'd2, 8'hC5, got);
   endtask

   task automatic test_back_to_back();
      logic [7:0] got;
      time        prev_t;
      run_cmd(OP_XOR, 2'd0, 2'd1, 2'd2, 0, 1'b0, 2'd0, 8'h00, got);
      for (int i = 0; i < 3; i++) begin
         prev_t = accept_t;
         run_cmd(3'(i + 1), 2'd2, 2'd1, 2'd2, 0, 1'b0, 2'd0, 8'h00, got);
         n_cmp++;
         if (accept_t - prev_t != 4 * CLK_PERIOD) begin
            n_err++; $display("FAIL throughput: got %0t want %0t", accept_t - prev_t, 4 * CLK_PERIOD);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] got;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) preload(2'($urandom), 8'($urandom));
         run_cmd(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                 int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                 2'($urandom), 8'($urandom), got);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [7:0] got;
      preload(2'd0, 8'h5A);
      preload(2'd1, 8'hC3);
      preload(2'd2, 8'h77);
      preload(2'd3, 8'h11);
      run_cmd(OP_OR, 2'd0, 2'd1, 2'd3, 0, 1'b0, 2'd0, 8'h00, got);   // leaves rsp_data nonzero
      cmd_valid = 1'b1; cmd_op = OP_XOR; cmd_src_a = 2'd0; cmd_src_b = 2'd1; cmd_dst = 2'd2;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);                         // in the capture cycle now
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (lu_a !== 8'h00 || lu_b !== 8'h00 || lu_sel !== 3'd0 || rsp_valid !== 1'b0 ||
          rsp_data !== 8'h00 || rsp_zero !== 1'b0 || rsp_parity !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: got a=%h b=%h sel=%0d v=%b d=%h z=%b p=%b want all 0",
                  lu_a, lu_b, lu_sel, rsp_valid, rsp_data, rsp_zero, rsp_parity);
      end
      for (int i = 0; i < 4; i++) rf_m[i] = 8'h00;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL post_reset_idle: got v=%b ready=%b want 0/1", rsp_valid, cmd_ready);
         end
      end
      run_cmd(OP_NAND, 2'd0, 2'd1, 2'd0, 0, 1'b0, 2'd0, 8'h00, got);
      n_cmp++;
      if (got !== 8'hFF) begin n_err++; $display("FAIL rf_cleared: got %h want ff", got); end
      for (int r = 1; r < 4; r++) begin
         run_cmd(OP_PASSB, 2'd0, 2'(r), 2'(r), 0, 1'b0, 2'd0, 8'h00, got);
      end
   endtask

   initial begin
      test_reset();
      test_basic_ops();
      test_stall();
      test_zero_hazard();
      test_preload_same_cycle();
      test_back_to_back();
      test_random();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #(CLK_PERIOD * 20000);
      $display("FAIL watchdog: got no completion want completion within 20000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
